// File: rtl/led_matrix_pkg.sv
// Shared constants, state encoding and column helpers for the 5x7 LED matrix column scanner.
package led_matrix_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;
  localparam int IMAGE_W  = 35;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  localparam logic [4:0] COLS_OFF = 5'b11111;
  localparam logic [2:0] LAST_COL = 3'd4;

  function automatic logic [4:0] col_strobe(input logic [2:0] col);
    case (col)
      3'd0:    return 5'b11110;
      3'd1:    return 5'b11101;
      3'd2:    return 5'b11011;
      3'd3:    return 5'b10111;
      3'd4:    return 5'b01111;
      default: return COLS_OFF;
    endcase
  endfunction

  // Row slice of the image for one column; bit 7*c+r is row r of column c.
  function automatic logic [6:0] col_rows(input logic [34:0] img, input logic [2:0] col);
    case (col)
      3'd0:    return img[6:0];
      3'd1:    return img[13:7];
      3'd2:    return img[20:14];
      3'd3:    return img[27:21];
      3'd4:    return img[34:28];
      default: return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/led_matrix_column_scanner_timer.sv
// Shared phase counter for BLANK and DRIVE: counts 0..target-1, holds at terminal count, clears on request.
module led_scan_timer
  import led_matrix_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] target,
  output logic             done,
  output logic [CNT_W-1:0] count_next
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    done = (count_q == (target - CNT_W'(1)));
    if (clear) begin
      count_d = '0;
    end else if (done) begin
      count_d = count_q;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
    count_next = count_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_matrix_column_scanner.sv
// Time-multiplexes a 35-bit 5x7 image onto the LED matrix one blanked column at a time.
// Optional PWM dimming via brightness[2:0] when LED_MATRIX_DIMMING_EN is defined.
module led_matrix_column_scanner
  import led_matrix_pkg::*;
#(
  parameter int DRIVE_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [34:0] rows_values,
`ifdef LED_MATRIX_DIMMING_EN
  input  logic [2:0]  brightness,
`endif
  output logic [4:0]  columns,
  output logic [6:0]  rows,
  output logic        frame_start,
  output logic [2:0]  col_index
);

  localparam int OW = CNT_W + 3;
  localparam logic [CNT_W-1:0] DRIVE_T = CNT_W'(DRIVE_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_T = CNT_W'(BLANK_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [2:0]       col_q, col_d;
  logic [34:0]      frame_buf_q, frame_buf_d;
  logic [4:0]       columns_q, columns_d;
  logic [6:0]       rows_q, rows_d;
  logic             frame_start_q, frame_start_d;
  logic             latch_s;
  logic             timer_clear_s;
  logic             timer_done_s;
  logic [CNT_W-1:0] timer_target_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic [OW-1:0]    on_cycles_s;
  logic             drive_on_s;
`ifdef LED_MATRIX_DIMMING_EN
  logic [2:0]       brightness_q, brightness_d;
`endif

  led_scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (timer_clear_s),
    .target     (timer_target_s),
    .done       (timer_done_s),
    .count_next (cnt_next_s)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    latch_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        col_d = 3'd0;
        if (enable) begin
          latch_s = 1'b1;
          state_d = ST_BLANK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_d = ST_IDLE;
          col_d   = 3'd0;
        end else if (timer_done_s) begin
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_BLANK;
        end
      end
      ST_DRIVE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          col_d   = 3'd0;
        end else if (timer_done_s) begin
          state_d = ST_BLANK;
          if (col_q == LAST_COL) begin
            col_d   = 3'd0;
            latch_s = 1'b1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end else begin
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = 3'd0;
      end
    endcase
  end

  // Image (and brightness) are captured only at frame boundaries so a frame is never torn.
  always_comb begin
    frame_buf_d   = frame_buf_q;
    frame_start_d = 1'b0;
    if (latch_s) begin
      frame_buf_d   = rows_values;
      frame_start_d = 1'b1;
    end else begin
      frame_buf_d   = frame_buf_q;
      frame_start_d = 1'b0;
    end
`ifdef LED_MATRIX_DIMMING_EN
    brightness_d = brightness_q;
    if (latch_s) begin
      brightness_d = brightness;
    end else begin
      brightness_d = brightness_q;
    end
`endif
  end

  always_comb begin
    timer_clear_s  = (state_d != state_q) || (state_q == ST_IDLE);
    timer_target_s = (state_q == ST_BLANK) ? BLANK_T : DRIVE_T;
  end

  // Outputs are computed from next-state values so they change on the same edge as the state.
  always_comb begin
`ifdef LED_MATRIX_DIMMING_EN
    on_cycles_s = ((OW'(brightness_d) + OW'(1)) * OW'(DRIVE_CYCLES)) >> 3'd3;
`else
    on_cycles_s = OW'(DRIVE_CYCLES);
`endif
    drive_on_s = (state_d == ST_DRIVE) && (OW'(cnt_next_s) < on_cycles_s);
    if (drive_on_s) begin
      columns_d = col_strobe(col_d);
      rows_d    = col_rows(frame_buf_d, col_d);
    end else begin
      columns_d = COLS_OFF;
      rows_d    = 7'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      col_q         <= 3'd0;
      frame_buf_q   <= 35'd0;
      columns_q     <= COLS_OFF;
      rows_q        <= 7'd0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      frame_buf_q   <= frame_buf_d;
      columns_q     <= columns_d;
      rows_q        <= rows_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef LED_MATRIX_DIMMING_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      brightness_q <= 3'd0;
    end else begin
      brightness_q <= brightness_d;
    end
  end
`endif

  assign columns     = columns_q;
  assign rows        = rows_q;
  assign frame_start = frame_start_q;
  assign col_index   = col_q;

endmodule
